// File: rtl/ofdm_rx_symbol_collector.sv
// OFDM receive symbol collector: gathers 16 samples, hands them to the FFT
// core, then latches the 1/2/4/8 Hz subcarriers from the result.
module ofdm_rx_symbol_collector #(
    parameter int N       = 16,
    parameter int PTS     = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [N-1:0]     i_re,
    input  logic [N-1:0]     i_im,
    output logic             o_ready,
    output logic [PTS*N-1:0] o_fft_re,
    output logic [PTS*N-1:0] o_fft_im,
    output logic             o_fft_start,
    input  logic [PTS*N-1:0] i_fft_re,
    input  logic [PTS*N-1:0] i_fft_im,
    input  logic             i_fft_done,
    output logic [N-1:0]     o_1Hz_re,
    output logic [N-1:0]     o_1Hz_im,
    output logic [N-1:0]     o_2Hz_re,
    output logic [N-1:0]     o_2Hz_im,
    output logic [N-1:0]     o_4Hz_re,
    output logic [N-1:0]     o_4Hz_im,
    output logic [N-1:0]     o_8Hz_re,
    output logic [N-1:0]     o_8Hz_im,
    output logic             o_sym_valid,
    output logic [7:0]       o_sym_cnt,
    output logic             o_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        COLLECT,
        SEND,
        WAIT,
        LATCH
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    wr_idx;
    logic [N-1:0]  buf_re [PTS];
    logic [N-1:0]  buf_im [PTS];
    logic [TW-1:0] to_cnt;
    logic          run;
    logic          accept;
    logic          done_hit;
    logic          to_hit;
    logic          unused_bins;

    // run keeps o_ready low until the first edge after reset release
    assign o_ready  = run && (state == COLLECT);
    assign accept   = i_valid && o_ready;
    assign done_hit = (state == WAIT) && i_fft_done;
    assign to_hit   = (state == WAIT) && !i_fft_done
                   && (to_cnt == TW'(TIMEOUT - 1));

    assign unused_bins = ^{i_fft_re, i_fft_im};

    always_comb begin
        for (int k = 0; k < PTS; k++) begin
            o_fft_re[k*N +: N] = buf_re[k];
            o_fft_im[k*N +: N] = buf_im[k];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= COLLECT;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        o_fft_start = 1'b0;
        o_sym_valid = 1'b0;
        unique case (state)
            COLLECT: begin
                if (accept && wr_idx == 4'd15)
                    state_nxt = SEND;
            end
            SEND: begin
                o_fft_start = 1'b1;
                state_nxt   = WAIT;
            end
            WAIT: begin
                if (i_fft_done)
                    state_nxt = LATCH;
                else if (to_hit)
                    state_nxt = COLLECT;
            end
            LATCH: begin
                o_sym_valid = 1'b1;
                state_nxt   = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_idx    <= '0;
            to_cnt    <= '0;
            o_1Hz_re  <= '0;
            o_1Hz_im  <= '0;
            o_2Hz_re  <= '0;
            o_2Hz_im  <= '0;
            o_4Hz_re  <= '0;
            o_4Hz_im  <= '0;
            o_8Hz_re  <= '0;
            o_8Hz_im  <= '0;
            o_sym_cnt <= '0;
            o_timeout <= 1'b0;
            for (int k = 0; k < PTS; k++) begin
                buf_re[k] <= '0;
                buf_im[k] <= '0;
            end
        end else begin
            if (accept) begin
                buf_re[wr_idx] <= i_re;
                buf_im[wr_idx] <= i_im;
                wr_idx         <= wr_idx + 4'd1;
            end
            if (state == SEND)
                to_cnt <= '0;
            else if (state == WAIT)
                to_cnt <= to_cnt + TW'(1);
            // subcarriers 1/2/4/8 Hz live in bins 0/1/3/7
            if (done_hit) begin
                o_1Hz_re  <= i_fft_re[0*N +: N];
                o_1Hz_im  <= i_fft_im[0*N +: N];
                o_2Hz_re  <= i_fft_re[1*N +: N];
                o_2Hz_im  <= i_fft_im[1*N +: N];
                o_4Hz_re  <= i_fft_re[3*N +: N];
                o_4Hz_im  <= i_fft_im[3*N +: N];
                o_8Hz_re  <= i_fft_re[7*N +: N];
                o_8Hz_im  <= i_fft_im[7*N +: N];
                o_sym_cnt <= o_sym_cnt + 8'd1;
            end
            if (to_hit)
                o_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ofdm_rx_symbol_collector.sv
// Bench for ofdm_rx_symbol_collector: random sample streams checked against
// a queue-based symbol model and a stub FFT core with programmable latency.
module tb_ofdm_rx_symbol_collector;

    localparam int N       = 16;
    localparam int PTS     = 16;
    localparam int TIMEOUT = 255;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b0;
    logic             i_valid = 1'b0;
    logic [N-1:0]     i_re = '0;
    logic [N-1:0]     i_im = '0;
    logic             o_ready;
    logic [PTS*N-1:0] o_fft_re;
    logic [PTS*N-1:0] o_fft_im;
    logic             o_fft_start;
    logic [PTS*N-1:0] i_fft_re = '0;
    logic [PTS*N-1:0] i_fft_im = '0;
    logic             i_fft_done = 1'b0;
    logic [N-1:0]     o_1Hz_re, o_1Hz_im, o_2Hz_re, o_2Hz_im;
    logic [N-1:0]     o_4Hz_re, o_4Hz_im, o_8Hz_re, o_8Hz_im;
    logic             o_sym_valid;
    logic [7:0]       o_sym_cnt;
    logic             o_timeout;

    int tests   = 0;
    int fails   = 0;
    int exp_cnt = 0;
    int sc_bin [4] = '{0, 1, 3, 7};

    logic [N-1:0] q_re [$];
    logic [N-1:0] q_im [$];
    logic [N-1:0] bre [PTS];
    logic [N-1:0] bim [PTS];

    ofdm_rx_symbol_collector #(
        .N(N), .PTS(PTS), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid(i_valid), .i_re(i_re), .i_im(i_im),
        .o_ready(o_ready),
        .o_fft_re(o_fft_re), .o_fft_im(o_fft_im),
        .o_fft_start(o_fft_start),
        .i_fft_re(i_fft_re), .i_fft_im(i_fft_im),
        .i_fft_done(i_fft_done),
        .o_1Hz_re(o_1Hz_re), .o_1Hz_im(o_1Hz_im),
        .o_2Hz_re(o_2Hz_re), .o_2Hz_im(o_2Hz_im),
        .o_4Hz_re(o_4Hz_re), .o_4Hz_im(o_4Hz_im),
        .o_8Hz_re(o_8Hz_re), .o_8Hz_im(o_8Hz_im),
        .o_sym_valid(o_sym_valid),
        .o_sym_cnt(o_sym_cnt),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [N-1:0] sc_re(input int j);
        case (j)
            0: return o_1Hz_re;
            1: return o_2Hz_re;
            2: return o_4Hz_re;
            default: return o_8Hz_re;
        endcase
    endfunction

    function automatic logic [N-1:0] sc_im(input int j);
        case (j)
            0: return o_1Hz_im;
            1: return o_2Hz_im;
            2: return o_4Hz_im;
            default: return o_8Hz_im;
        endcase
    endfunction

    // Source + FFT stub + reference model. lat==0 picks a random latency.
    task automatic run_stream(input int nsym, input int vpct, input int lat,
                              input bit hold, input bit ramp,
                              input bit fixed_bins);
        int acc = 0;
        int seq = 0;
        int fed = 0;
        int got = 0;
        int wait_cnt = 0;
        int budget;
        bit waiting = 0;
        bit start_due = 0;
        bit strobe_due = 0;
        bit busy = 0;
        bit free_next = 0;
        bit v;
        bit err;
        logic [N-1:0] p_re;
        logic [N-1:0] p_im;
        budget = nsym * 60 + 50;
        p_re = ramp ? N'(0) : N'($urandom);
        p_im = ramp ? N'(0) : N'($urandom);
        i_fft_done = 1'b0;
        i_valid = 1'b0;
        while (got < nsym && budget > 0) begin
            step();
            budget--;
            if (free_next) begin
                busy = 0;
                free_next = 0;
                tests++;
                if (o_sym_cnt !== 8'(exp_cnt)) begin
                    fails++;
                    $display("FAIL sym_cnt: got %0d want %0d",
                             o_sym_cnt, 8'(exp_cnt));
                end
            end
            tests++;
            if (o_fft_start !== start_due) begin
                fails++;
                $display("FAIL fft_start: got %b want %b",
                         o_fft_start, start_due);
            end
            tests++;
            if (o_sym_valid !== strobe_due) begin
                fails++;
                $display("FAIL sym_valid: got %b want %b",
                         o_sym_valid, strobe_due);
            end
            if (strobe_due) begin
                for (int j = 0; j < 4; j++) begin
                    tests++;
                    if (sc_re(j) !== bre[sc_bin[j]] ||
                        sc_im(j) !== bim[sc_bin[j]]) begin
                        fails++;
                        $display("FAIL subcarrier%0d: got %h/%h want %h/%h",
                                 j, sc_re(j), sc_im(j),
                                 bre[sc_bin[j]], bim[sc_bin[j]]);
                    end
                end
                got++;
                exp_cnt++;
                free_next = 1;
                strobe_due = 0;
            end
            tests++;
            if (o_ready !== !busy) begin
                fails++;
                $display("FAIL ready: got %b want %b", o_ready, !busy);
            end
            i_fft_done = 1'b0;
            if (waiting) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    i_fft_done = 1'b1;
                    waiting = 0;
                    strobe_due = 1;
                end
            end
            if (start_due) begin
                err = 0;
                tests++;
                if (q_re.size() < PTS) begin
                    err = 1;
                    q_re.delete();
                    q_im.delete();
                end else begin
                    for (int k = 0; k < PTS; k++) begin
                        if (o_fft_re[k*N +: N] !== q_re[0] ||
                            o_fft_im[k*N +: N] !== q_im[0])
                            err = 1;
                        void'(q_re.pop_front());
                        void'(q_im.pop_front());
                    end
                end
                if (err) begin
                    fails++;
                    $display("FAIL symbol_buf: got %h / %h",
                             o_fft_re, o_fft_im);
                end
                for (int k = 0; k < PTS; k++) begin
                    bre[k] = fixed_bins ? N'(16'h100 + k) : N'($urandom);
                    bim[k] = fixed_bins ? N'(16'h200 + k) : N'($urandom);
                    i_fft_re[k*N +: N] = bre[k];
                    i_fft_im[k*N +: N] = bim[k];
                end
                waiting = 1;
                wait_cnt = (lat == 0) ? int'($urandom_range(1, 12)) : lat;
                start_due = 0;
            end
            v = ($urandom_range(99) < vpct) && (fed < nsym);
            if (busy && hold)
                v = 1;
            i_valid = v;
            i_re = p_re;
            i_im = p_im;
            if (v && !busy) begin
                q_re.push_back(p_re);
                q_im.push_back(p_im);
                seq++;
                acc++;
                p_re = ramp ? N'(seq) : N'($urandom);
                p_im = ramp ? N'(-seq) : N'($urandom);
                if (acc == PTS) begin
                    acc = 0;
                    fed++;
                    busy = 1;
                    start_due = 1;
                end
            end
        end
        i_valid = 1'b0;
        i_fft_done = 1'b0;
        if (got < nsym) begin
            tests++;
            fails++;
            $display("FAIL stream_budget: got %0d symbols want %0d",
                     got, nsym);
        end
        step();
        tests++;
        if (o_ready !== 1'b1 || o_sym_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL stream_end: ready %b cnt %0d want 1 cnt %0d",
                     o_ready, o_sym_cnt, 8'(exp_cnt));
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0", o_ready);
        end
        tests++;
        if ({o_fft_start, o_sym_valid, o_timeout} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got %b want 000",
                     {o_fft_start, o_sym_valid, o_timeout});
        end
        tests++;
        if ({o_fft_re, o_fft_im} !== '0 || o_sym_cnt !== 8'd0) begin
            fails++;
            $display("FAIL reset_data: cnt %0d fft %h want 0",
                     o_sym_cnt, o_fft_re);
        end
        i_rst = 1'b1;
        #2;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL release_early: got %b want 0", o_ready);
        end
        step();
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL release_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_ramp();
        run_stream(1, 100, 5, 0, 1, 1);
        tests++;
        if (o_1Hz_re !== 16'h0100 || o_1Hz_im !== 16'h0200) begin
            fails++;
            $display("FAIL bin_1Hz: got %h/%h want 0100/0200",
                     o_1Hz_re, o_1Hz_im);
        end
        tests++;
        if (o_2Hz_re !== 16'h0101 || o_2Hz_im !== 16'h0201) begin
            fails++;
            $display("FAIL bin_2Hz: got %h/%h want 0101/0201",
                     o_2Hz_re, o_2Hz_im);
        end
        tests++;
        if (o_4Hz_re !== 16'h0103 || o_4Hz_im !== 16'h0203) begin
            fails++;
            $display("FAIL bin_4Hz: got %h/%h want 0103/0203",
                     o_4Hz_re, o_4Hz_im);
        end
        tests++;
        if (o_8Hz_re !== 16'h0107 || o_8Hz_im !== 16'h0207) begin
            fails++;
            $display("FAIL bin_8Hz: got %h/%h want 0107/0207",
                     o_8Hz_re, o_8Hz_im);
        end
        tests++;
        if (o_sym_cnt !== 8'd1) begin
            fails++;
            $display("FAIL ramp_cnt: got %0d want 1", o_sym_cnt);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 7; k++) begin
            i_valid = 1'b1;
            i_re = N'($urandom) | N'(1);
            i_im = N'($urandom) | N'(1);
            step();
        end
        i_valid = 1'b0;
        #2;
        i_rst = 1'b0;
        #1;
        exp_cnt = 0;
        tests++;
        if ({o_ready, o_fft_start, o_sym_valid, o_timeout} !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_flags: got %b want 0000",
                     {o_ready, o_fft_start, o_sym_valid, o_timeout});
        end
        tests++;
        if ({o_fft_re, o_fft_im} !== '0) begin
            fails++;
            $display("FAIL midreset_buf: got %h want 0", o_fft_re);
        end
        tests++;
        if ({o_1Hz_re, o_1Hz_im, o_2Hz_re, o_2Hz_im, o_4Hz_re, o_4Hz_im,
             o_8Hz_re, o_8Hz_im} !== '0 || o_sym_cnt !== 8'd0) begin
            fails++;
            $display("FAIL midreset_out: cnt %0d 1Hz %h want 0",
                     o_sym_cnt, o_1Hz_re);
        end
        step();
        i_rst = 1'b1;
        #2;
        tests++;
        if (o_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrelease_early: got %b want 0", o_ready);
        end
        step();
        tests++;
        if (o_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrelease_ready: got %b want 1", o_ready);
        end
    endtask

    task automatic test_backpressure();
        run_stream(4, 50, 0, 1, 0, 0);
        tests++;
        if (o_sym_cnt !== 8'd4) begin
            fails++;
            $display("FAIL bp_cnt: got %0d want 4", o_sym_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_stream(3, 100, 1, 1, 0, 0);
    endtask

    task automatic test_timeout();
        logic [N-1:0] keep;
        int bad = 0;
        keep = o_4Hz_re;
        i_valid = 1'b1;
        for (int k = 0; k < PTS; k++) begin
            i_re = N'($urandom);
            i_im = N'($urandom);
            step();
        end
        i_valid = 1'b0;
        tests++;
        if (o_fft_start !== 1'b1) begin
            fails++;
            $display("FAIL to_start: got %b want 1", o_fft_start);
        end
        for (int j = 1; j <= TIMEOUT; j++) begin
            step();
            if (o_timeout !== 1'b0 || o_ready !== 1'b0 || o_sym_valid !== 1'b0)
                bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL to_wait: %0d bad cycles want 0", bad);
        end
        step();
        tests++;
        if ({o_timeout, o_ready, o_sym_valid} !== 3'b110) begin
            fails++;
            $display("FAIL to_expire: got %b want 110",
                     {o_timeout, o_ready, o_sym_valid});
        end
        for (int k = 0; k < PTS; k++) begin
            i_fft_re[k*N +: N] = N'($urandom);
            i_fft_im[k*N +: N] = N'($urandom);
        end
        i_fft_done = 1'b1;
        bad = 0;
        repeat (3) begin
            step();
            if (o_sym_valid !== 1'b0 || o_4Hz_re !== keep ||
                o_sym_cnt !== 8'(exp_cnt))
                bad++;
        end
        i_fft_done = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL spurious_done: %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_wrap();
        run_stream(256 - (exp_cnt % 256), 100, 1, 0, 0, 0);
        tests++;
        if (o_sym_cnt !== 8'd0) begin
            fails++;
            $display("FAIL wrap_cnt: got %0d want 0", o_sym_cnt);
        end
        tests++;
        if (o_timeout !== 1'b1) begin
            fails++;
            $display("FAIL timeout_sticky: got %b want 1", o_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reset_mid();
        test_backpressure();
        test_back_to_back();
        test_timeout();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
